// File: rtl/seq_div_if.sv
// Operand/result handshake bundle for seq_div.
// The master drives the operands and out_ready; the slave (the divider) returns the results.
interface seq_div_if #(
  parameter int WIDTH = 1024
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_div.sv
// Sequential radix-2 restoring divider: one quotient bit per clock through a
// WIDTH+1-bit ripple subtractor (rca with inverted b and cin = 1).

module rca #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  always_comb begin : ripple
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end
endmodule

module seq_div #(
  parameter int WIDTH = 1024
) (
  input  logic   clk,
  input  logic   rst,
  seq_div_if.slave bus
);
  // state | meaning
  // IDLE  | accepting a new dividend/divisor pair
  // BUSY  | retiring one quotient bit per cycle, bit counter running down
  // DONE  | result held stable until the consumer takes it
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic             dz_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   diff;
  logic             no_borrow;

  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign sub_b = ~{1'b0, dsr_q};

  rca #(.W(WIDTH + 1)) u_sub (
    .a   (trial),
    .b   (sub_b),
    .cin (1'b1),
    .sum (diff),
    .cout(no_borrow)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dsr_q <= bus.divisor;
            // a zero divisor skips the iteration and reports all-ones / dividend
            if (bus.divisor == '0) begin
              quo_q <= '1;
              rem_q <= bus.dividend;
              dz_q  <= 1'b1;
              cnt   <= '0;
              state <= DONE;
            end else begin
              quo_q <= bus.dividend;
              rem_q <= '0;
              dz_q  <= 1'b0;
              cnt   <= CNT_LOAD;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          // remainder stays below the divisor, so the low WIDTH bits hold it
          if (no_borrow) begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div at WIDTH=8: directed vectors with literal
// expectations plus a per-cycle compare against an arithmetic reference model.
module tb_seq_div;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  bit   checking;

  seq_div_if #(.WIDTH(W)) bus ();

  seq_div #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: result from plain division, visibility from the cycle rules
  bit           m_idle;
  bit           m_valid;
  int           m_left;
  logic [W-1:0] m_q;
  logic [W-1:0] m_r;
  logic         m_dz;

  initial begin
    m_idle = 1'b1; m_valid = 1'b0; m_left = 0;
    m_q = '0; m_r = '0; m_dz = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_valid = 1'b0; m_left = 0;
      m_q = '0; m_r = '0; m_dz = 1'b0;
    end else if (m_idle) begin
      if (bus.in_valid) begin
        m_idle = 1'b0;
        if (bus.divisor == '0) begin
          m_q = '1; m_r = bus.dividend; m_dz = 1'b1; m_left = 0;
        end else begin
          m_q = bus.dividend / bus.divisor;
          m_r = bus.dividend % bus.divisor;
          m_dz = 1'b0; m_left = W;
        end
        m_valid = (m_left == 0);
      end
    end else if (!m_valid) begin
      m_left = m_left - 1;
      if (m_left == 0) m_valid = 1'b1;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
      m_idle  = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("model in_ready", W'(bus.in_ready), W'(m_idle));
      chk("model out_valid", W'(bus.out_valid), W'(m_valid));
      if (m_idle || m_valid) begin
        chk("model quotient", bus.quotient, m_q);
        chk("model remainder", bus.remainder, m_r);
        chk("model div_zero", W'(bus.div_zero), W'(m_dz));
      end
    end
  end

  // one full operation; busy cycles counted from the first negedge after accept
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                       input bit poke, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input int elat);
    int lat;
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 4 * W) begin
      if (poke && lat == 2) begin
        bus.dividend = 8'd9; bus.divisor = 8'd2; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk_int($sformatf("latency %0d/%0d", a, b), lat, elat);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = (poke && h == 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk($sformatf("out_valid %0d/%0d", a, b), W'(bus.out_valid), W'(1));
    chk($sformatf("quotient %0d/%0d", a, b), bus.quotient, eq);
    chk($sformatf("remainder %0d/%0d", a, b), bus.remainder, er);
    chk($sformatf("div_zero %0d/%0d", a, b), W'(bus.div_zero), W'(edz));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk($sformatf("in_ready after release %0d/%0d", a, b), W'(bus.in_ready), W'(1));
  endtask

  initial begin
    n_checks = 0; n_pass = 0; checking = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    chk("reset in_ready", W'(bus.in_ready), W'(1));
    chk("reset out_valid", W'(bus.out_valid), W'(0));
    chk("reset quotient", bus.quotient, 8'd0);
    chk("reset remainder", bus.remainder, 8'd0);

    do_op(8'd200, 8'd7,   0, 1'b0, 8'd28,  8'd4,  1'b0, W);
    do_op(8'd255, 8'd1,   0, 1'b0, 8'd255, 8'd0,  1'b0, W);
    do_op(8'd5,   8'd9,   0, 1'b0, 8'd0,   8'd5,  1'b0, W);
    do_op(8'd255, 8'd255, 0, 1'b0, 8'd1,   8'd0,  1'b0, W);
    do_op(8'd17,  8'd0,   0, 1'b0, 8'd255, 8'd17, 1'b1, 0);

    // backpressure with operand pokes while busy and done
    do_op(8'd100, 8'd3, 5, 1'b1, 8'd33, 8'd1, 1'b0, W);
    do_op(8'd9,   8'd2, 0, 1'b0, 8'd4,  8'd1, 1'b0, W);

    // reset three cycles into a division
    @(negedge clk);
    bus.dividend = 8'd200; bus.divisor = 8'd7; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midop reset in_ready", W'(bus.in_ready), W'(1));
    chk("midop reset out_valid", W'(bus.out_valid), W'(0));
    chk("midop reset quotient", bus.quotient, 8'd0);
    chk("midop reset remainder", bus.remainder, 8'd0);
    chk("midop reset div_zero", W'(bus.div_zero), W'(0));
    do_op(8'd50, 8'd6, 0, 1'b0, 8'd8, 8'd2, 1'b0, W);

    // reset and in_valid together: nothing accepted
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b1; bus.dividend = 8'd17; bus.divisor = 8'd0;
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0;
    chk("rst+valid in_ready", W'(bus.in_ready), W'(1));
    chk("rst+valid out_valid", W'(bus.out_valid), W'(0));
    @(negedge clk);
    chk("rst+valid still idle", W'(bus.out_valid), W'(0));

    for (int k = 0; k < 150; k++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, 255));
      case (k % 10)
        0:       b = '0;
        1:       b = 8'd1;
        2:       b = (a == 8'd255) ? 8'd255 : a + 8'd1;
        default: b = W'($urandom_range(1, 255));
      endcase
      if (b == '0) do_op(a, b, k % 3, 1'b0, 8'd255, a, 1'b1, 0);
      else         do_op(a, b, k % 3, 1'b0, a / b, a % b, 1'b0, W);
    end

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
